// File: rtl/execution_unit.sv
// rtl/execution_unit.sv - LEGv8-subset execute stage: control decode, ALU, branch resolve, data memory.
// Optional feature macro: XZR_PROTECT_EN (suppresses write-back reporting for register 31).
module execution_unit #(
  parameter int DMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic [31:0] instr,
  input  logic [63:0] imm_sext,
  input  logic [63:0] rd_data1,
  input  logic [63:0] rd_data2,
  output logic [63:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_toggle,
  output logic [63:0] branch_addr,
  output logic        pc_src
);

  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_CBNZ
  } op_t;

  op_t         op;
  logic [63:0] alu_b;
  logic [63:0] alu_res;
  logic        zero;
  logic        take;
  logic        reg_write;
  logic        do_write;
  logic [63:0] wb_next;
  logic [AW-1:0] mem_idx;
  logic [63:0] mem [DMEM_DEPTH];
  logic        fresh;
  logic        unused_bits;

  assign unused_bits = ^instr[20:5];

  always_comb begin
    op = OP_NOP;
    casez (instr[31:21])
      11'b10001011000: op = OP_ADD;
      11'b11001011000: op = OP_SUB;
      11'b10001010000: op = OP_AND;
      11'b10101010000: op = OP_ORR;
      11'b1001000100?: op = OP_ADDI;
      11'b1101000100?: op = OP_SUBI;
      11'b11111000010: op = OP_LDUR;
      11'b11111000000: op = OP_STUR;
      11'b000101?????: op = OP_B;
      11'b10110100???: op = OP_CBZ;
      11'b10110101???: op = OP_CBNZ;
      default:         op = OP_NOP;
    endcase
  end

  // CBZ/CBNZ pass Rt straight through so the zero flag doubles as the branch test
  always_comb begin
    alu_b = rd_data2;
    if (op inside {OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR}) alu_b = imm_sext;
    case (op)
      OP_ADD, OP_ADDI, OP_LDUR, OP_STUR: alu_res = rd_data1 + alu_b;
      OP_SUB, OP_SUBI:                   alu_res = rd_data1 - alu_b;
      OP_AND:                            alu_res = rd_data1 & alu_b;
      OP_ORR:                            alu_res = rd_data1 | alu_b;
      default:                           alu_res = alu_b;
    endcase
  end

  assign zero      = (alu_res == 64'd0);
  assign take      = (op == OP_B) | ((op == OP_CBZ) & zero) | ((op == OP_CBNZ) & ~zero);
  assign mem_idx   = alu_res[3+AW-1:3];
  assign reg_write = op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI, OP_LDUR};
  assign wb_next   = (op == OP_LDUR) ? mem[mem_idx] : alu_res;

`ifdef XZR_PROTECT_EN
  assign do_write = reg_write & (instr[4:0] != 5'd31);
`else
  assign do_write = reg_write;
`endif

  // fresh marks the first edge after reset release; that edge's instruction is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh       <= 1'b1;
      wb_data     <= '0;
      wb_reg      <= '0;
      wb_toggle   <= 1'b0;
      branch_addr <= '0;
      pc_src      <= 1'b0;
      for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      fresh <= 1'b0;
      if (!fresh) begin
        branch_addr <= pc_in + (imm_sext << 2);
        pc_src      <= take;
        if (do_write) begin
          wb_data   <= wb_next;
          wb_reg    <= instr[4:0];
          wb_toggle <= ~wb_toggle;
        end
        if (op == OP_STUR) mem[mem_idx] <= rd_data2;
      end
    end
  end

endmodule

// File: tb/tb_execution_unit.sv
// tb/tb_execution_unit.sv - randomized self-checking bench for execution_unit against a behavioural model.
module tb_execution_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_in, imm_sext, rd_data1, rd_data2;
  logic [31:0] instr;
  logic [63:0] wb_data, branch_addr;
  logic [4:0]  wb_reg;
  logic        wb_toggle, pc_src;

  int errors = 0;
  int checks = 0;

  logic [63:0] mmem [32];
  logic [63:0] e_wb_data, e_baddr;
  logic [4:0]  e_wb_reg;
  logic        e_tog, e_pc_src;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDO = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [9:0]  ADDI = 10'b1001000100;
  localparam logic [9:0]  SUBI = 10'b1101000100;
  localparam logic [5:0]  BOP  = 6'b000101;
  localparam logic [7:0]  CBZ  = 8'b10110100;
  localparam logic [7:0]  CBNZ = 8'b10110101;

  execution_unit #(.DMEM_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr(instr), .imm_sext(imm_sext),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_toggle(wb_toggle), .branch_addr(branch_addr), .pc_src(pc_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_wb_data"}, wb_data, e_wb_data);
    check({tag, "_wb_reg"}, 64'(wb_reg), 64'(e_wb_reg));
    check({tag, "_wb_toggle"}, 64'(wb_toggle), 64'(e_tog));
    check({tag, "_pc_src"}, 64'(pc_src), 64'(e_pc_src));
    check({tag, "_branch_addr"}, branch_addr, e_baddr);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mmem[i] = 64'd0;
    e_wb_data = 0; e_wb_reg = 0; e_tog = 0; e_pc_src = 0; e_baddr = 0;
  endtask

  // Present one instruction, advance one edge, compare with the architectural effect
  task automatic exec(input string tag, input logic [31:0] i, input logic [63:0] pc,
                      input logic [63:0] imm, input logic [63:0] r1, input logic [63:0] r2);
    logic [10:0] opc;
    logic [63:0] addr, res;
    int          idx;
    bit          wr, st;
    @(negedge clk);
    instr = i; pc_in = pc; imm_sext = imm; rd_data1 = r1; rd_data2 = r2;
    opc  = i[31:21];
    addr = r1 + imm;
    idx  = int'((addr >> 3) % 64'd32);
    wr = 1; st = 0; res = 0;
    if (opc == ADD)                  res = r1 + r2;
    else if (opc == SUB)             res = r1 - r2;
    else if (opc == ANDO)            res = r1 & r2;
    else if (opc == ORR)             res = r1 | r2;
    else if (opc[10:1] == ADDI)      res = r1 + imm;
    else if (opc[10:1] == SUBI)      res = r1 - imm;
    else if (opc == LDUR)            res = mmem[idx];
    else begin wr = 0; st = (opc == STUR); end
`ifdef XZR_PROTECT_EN
    if (i[4:0] == 5'd31) wr = 0;
`endif
    if (wr) begin e_wb_data = res; e_wb_reg = i[4:0]; e_tog = ~e_tog; end
    e_baddr  = pc + imm * 4;
    e_pc_src = (opc[10:5] == BOP) || (opc[10:3] == CBZ && r2 == 0) || (opc[10:3] == CBNZ && r2 != 0);
    @(posedge clk);
    #1;
    if (st) mmem[idx] = r2;
    check_all(tag);
  endtask

  // Reset asserted mid-cycle; a STUR held across the release edge must be dropped
  task automatic reset_seq(input logic [63:0] st_addr);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    instr = {STUR, 16'd0, 5'd0}; rd_data1 = st_addr; imm_sext = 0; rd_data2 = 64'h55AA; pc_in = 64'h40;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_release");
    exec("rst_ldur", {LDUR, 16'd0, 5'd4}, 0, 0, st_addr, 0);
    check("rst_ldur_zero", wb_data, 64'd0);
  endtask

  initial begin
    logic [31:0] r, ins;
    logic [63:0] a, b, im;
    int          k;
    rst = 1'b1;
    instr = 0; pc_in = 0; imm_sext = 0; rd_data1 = 0; rd_data2 = 0;
    model_reset();
    #1;
    check_all("por");
    reset_seq(64'd0);

    exec("add", {ADD, 16'd0, 5'd3}, 0, 0, 5, 7);
    check("add_12", wb_data, 64'd12);
    exec("sub", {SUB, 16'd0, 5'd4}, 0, 0, 0, 1);
    check("sub_neg1", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    exec("stur", {STUR, 16'd0, 5'd1}, 0, 8, 16, 64'hDEAD_BEEF);
    exec("ldur", {LDUR, 16'd0, 5'd9}, 0, 0, 24, 0);
    check("ldur_beef", wb_data, 64'hDEAD_BEEF);
    check("ldur_reg9", 64'(wb_reg), 64'd9);
    exec("cbz_t", {CBZ, 24'd0}, 100, 4, 0, 0);
    check("cbz_target", branch_addr, 64'd116);
    exec("cbz_nt", {CBZ, 24'd0}, 100, 4, 0, 1);
    exec("cbnz_t", {CBNZ, 24'd0}, 100, 4, 0, 1);
    exec("cbnz_nt", {CBNZ, 24'd0}, 100, 4, 0, 0);
    exec("b", {BOP, 26'd5}, 200, -64'sd2, 0, 0);
    check("b_target", branch_addr, 64'd192);
    exec("undef", 32'h0000_0000, 0, 0, 1, 2);
    exec("add_x31", {ADD, 16'd0, 5'd31}, 0, 0, 1, 1);
    exec("addi", {ADDI, 17'd0, 5'd7}, 0, 64'd100, 64'd23, 64'd9);
    exec("subi", {SUBI, 17'd0, 5'd8}, 0, 64'd3, 64'd1, 64'd9);

    for (int n = 0; n < 400; n++) begin
      r  = $urandom();
      k  = int'($urandom_range(0, 11));
      a  = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 511)) : {$urandom(), $urandom()};
      b  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
      im = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) im = -im;
      case (k)
        0:  ins = {ADD, r[20:0]};
        1:  ins = {SUB, r[20:0]};
        2:  ins = {ANDO, r[20:0]};
        3:  ins = {ORR, r[20:0]};
        4:  ins = {ADDI, r[21:0]};
        5:  ins = {SUBI, r[21:0]};
        6:  ins = {LDUR, r[20:0]};
        7:  ins = {STUR, r[20:0]};
        8:  ins = {BOP, r[25:0]};
        9:  ins = {CBZ, r[23:0]};
        10: ins = {CBNZ, r[23:0]};
        default: ins = r;
      endcase
      exec("rnd", ins, {$urandom(), $urandom()}, im, a, b);
    end

    reset_seq(64'd24);
    exec("post_add", {ADD, 16'd0, 5'd2}, 0, 0, 64'd40, 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
